// File: rtl/video_timing_pkg.sv
// Shared raster-timing definitions: standard display modes and the total-length helper
// used by the generator's elaboration checks.
package video_timing_pkg;

    typedef struct packed {
        int h_visible;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_visible;
        int v_fp;
        int v_sync;
        int v_bp;
        bit hsync_pol;
        bit vsync_pol;
    } video_mode_t;

    localparam video_mode_t SVGA_800X600_60 = '{
        h_visible: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_visible: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
        hsync_pol: 1'b1, vsync_pol: 1'b1
    };

    localparam video_mode_t VGA_640X480_60 = '{
        h_visible: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_visible: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        hsync_pol: 1'b0, vsync_pol: 1'b0
    };

    function automatic int calc_total(input int visible, input int fp, input int sync, input int bp);
        return visible + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Clock-enabled shift register that delays a sync signal by DEPTH pixels;
// every stage resets to INIT (the inactive level). DEPTH=0 is a plain wire.
module sync_delay_line #(
    parameter int   DEPTH = 1,
    parameter logic INIT  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic in,
    output logic out
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, ce};
        assign out = in;
    end else begin : g_shift
        logic [DEPTH-1:0] stage_q;
        logic [DEPTH-1:0] stage_d;

        // NOTE: every always_comb target gets a default first so no latch is inferred.
        always_comb begin
            stage_d = stage_q;
            if (ce) begin
                stage_d[0] = in;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        // NOTE: sequential state uses non-blocking assignments only.
        always_ff @(posedge clk) begin
            if (rst) stage_q <= {DEPTH{INIT}};
            else     stage_q <= stage_d;
        end

        assign out = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, sync pulses, visible flag,
// line/frame strobes and a completed-frame counter, all advancing on the pixel enable.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_VISIBLE  = SVGA_800X600_60.h_visible,
    parameter int H_FP       = SVGA_800X600_60.h_fp,
    parameter int H_SYNC     = SVGA_800X600_60.h_sync,
    parameter int H_BP       = SVGA_800X600_60.h_bp,
    parameter int V_VISIBLE  = SVGA_800X600_60.v_visible,
    parameter int V_FP       = SVGA_800X600_60.v_fp,
    parameter int V_SYNC     = SVGA_800X600_60.v_sync,
    parameter int V_BP       = SVGA_800X600_60.v_bp,
    parameter bit HSYNC_POL  = SVGA_800X600_60.hsync_pol,
    parameter bit VSYNC_POL  = SVGA_800X600_60.vsync_pol,
    parameter int SYNC_DELAY = 1,
    parameter int COUNT_W    = 16,
    parameter int FRAME_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    output logic [COUNT_W-1:0] hcount,
    output logic [COUNT_W-1:0] vcount,
    output logic               vis,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = calc_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

    if (COUNT_W <= 0 || FRAME_W <= 0) begin : g_bad_width
        $error("video_timing_gen: COUNT_W and FRAME_W must be non-zero");
    end
    if (longint'(H_TOTAL) > (longint'(1) << COUNT_W) ||
        longint'(V_TOTAL) > (longint'(1) << COUNT_W)) begin : g_bad_total
        $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 2**COUNT_W");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 15) begin : g_bad_delay
        $error("video_timing_gen: SYNC_DELAY must be 0..15");
    end

    // Window bounds carry one extra bit so a total of exactly 2**COUNT_W cannot alias to 0.
    localparam logic [COUNT_W-1:0] H_LAST     = COUNT_W'(H_TOTAL - 1);
    localparam logic [COUNT_W-1:0] V_LAST     = COUNT_W'(V_TOTAL - 1);
    localparam logic [COUNT_W:0]   H_VIS_END  = (COUNT_W+1)'(H_VISIBLE);
    localparam logic [COUNT_W:0]   V_VIS_END  = (COUNT_W+1)'(V_VISIBLE);
    localparam logic [COUNT_W:0]   HS_START   = (COUNT_W+1)'(H_VISIBLE + H_FP);
    localparam logic [COUNT_W:0]   HS_END     = (COUNT_W+1)'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [COUNT_W:0]   VS_START   = (COUNT_W+1)'(V_VISIBLE + V_FP);
    localparam logic [COUNT_W:0]   VS_END     = (COUNT_W+1)'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic               HS_IDLE    = ~HSYNC_POL;
    localparam logic               VS_IDLE    = ~VSYNC_POL;

    logic [COUNT_W-1:0] hcount_q, hcount_d;
    logic [COUNT_W-1:0] vcount_q, vcount_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               vis_q, vis_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;

    // Decode is done on the next counter values so every registered output
    // describes the hcount/vcount presented alongside it.
    always_comb begin
        hcount_d    = hcount_q;
        vcount_d    = vcount_q;
        frame_cnt_d = frame_cnt_q;
        if (ce) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                if (vcount_q == V_LAST) begin
                    vcount_d    = '0;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end else begin
                    vcount_d = vcount_q + 1'b1;
                end
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end

        vis_d         = ({1'b0, hcount_d} < H_VIS_END) && ({1'b0, vcount_d} < V_VIS_END);
        line_start_d  = (hcount_d == '0);
        frame_start_d = (hcount_d == '0) && (vcount_d == '0);
        hs_d = ({1'b0, hcount_d} >= HS_START && {1'b0, hcount_d} < HS_END) ? HSYNC_POL : HS_IDLE;
        vs_d = ({1'b0, vcount_d} >= VS_START && {1'b0, vcount_d} < VS_END) ? VSYNC_POL : VS_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_cnt_q   <= '0;
            vis_q         <= 1'b1;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
            hs_q          <= HS_IDLE;
            vs_q          <= VS_IDLE;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_cnt_q   <= frame_cnt_d;
            vis_q         <= vis_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
        end
    end

    sync_delay_line #(.DEPTH(SYNC_DELAY), .INIT(HS_IDLE)) u_hsync_delay (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .in  (hs_q),
        .out (hsync)
    );

    sync_delay_line #(.DEPTH(SYNC_DELAY), .INIT(VS_IDLE)) u_vsync_delay (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .in  (vs_q),
        .out (vsync)
    );

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign vis         = vis_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen in a 16x8 mode: instance a has default sync options,
// instance b has active-low hsync, a two-pixel sync delay and a 2-bit frame counter.
module tb_video_timing_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce  = 1'b0;

    logic [15:0] a_h, a_v, b_h, b_v;
    logic        a_vis, a_hs, a_vs, a_ls, a_fs;
    logic        b_vis, b_hs, b_vs, b_ls, b_fs;
    logic [7:0]  a_fc;
    logic [1:0]  b_fc;

    int n_checks = 0;
    int n_errors = 0;

    video_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .SYNC_DELAY(0),
        .COUNT_W(16), .FRAME_W(8)
    ) dut_a (
        .clk(clk), .rst(rst), .ce(ce),
        .hcount(a_h), .vcount(a_v), .vis(a_vis), .hsync(a_hs), .vsync(a_vs),
        .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
    );

    video_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .SYNC_DELAY(2),
        .COUNT_W(16), .FRAME_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .ce(ce),
        .hcount(b_h), .vcount(b_v), .vis(b_vis), .hsync(b_hs), .vsync(b_vs),
        .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-pixel outputs for the 16x8 mode, from the hand-listed windows.
    task automatic check_state(input int eh, input int ev);
        check("a_hcount", a_h, eh);
        check("a_vcount", a_v, ev);
        check("a_vis", a_vis, (eh < 8 && ev < 4) ? 1 : 0);
        check("a_line_start", a_ls, (eh == 0) ? 1 : 0);
        check("a_frame_start", a_fs, (eh == 0 && ev == 0) ? 1 : 0);
        check("a_hsync", a_hs, (eh >= 10 && eh <= 12) ? 1 : 0);
        check("a_vsync", a_vs, (ev == 5 || ev == 6) ? 1 : 0);
        check("b_hcount", b_h, eh);
        check("b_hsync_n", b_hs, (eh >= 12 && eh <= 14) ? 0 : 1);
    endtask

    task automatic measure_period(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            ce = 1'($urandom_range(0, 1));
            tick();
            if (ce) n++;
            if (ce && a_fs) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int eh, ev, fs_cnt, vis_cnt, vs_cnt, n;
        bit ok;

        // Reset state
        rst = 1'b1; ce = 1'b0;
        tick(); tick();
        check("rst_hcount", a_h, 0);
        check("rst_vcount", a_v, 0);
        check("rst_vis", a_vis, 1);
        check("rst_line_start", a_ls, 1);
        check("rst_frame_start", a_fs, 1);
        check("rst_frame_cnt", a_fc, 0);
        check("rst_a_hsync", a_hs, 0);
        check("rst_a_vsync", a_vs, 0);
        check("rst_b_hsync_n", b_hs, 1);
        check("rst_b_vsync", b_vs, 0);

        // One full frame with ce held high
        rst = 1'b0; ce = 1'b1;
        eh = 0; ev = 0; fs_cnt = 0; vis_cnt = 0; vs_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            check_state(eh, ev);
            fs_cnt  += int'(a_fs);
            vis_cnt += int'(a_vis);
            vs_cnt  += int'(a_vs);
            tick();
            if (eh == 15) begin
                eh = 0;
                ev = (ev == 7) ? 0 : ev + 1;
            end else begin
                eh++;
            end
        end
        check("frame_start_count", fs_cnt, 1);
        check("vis_count", vis_cnt, 32);
        check("vsync_count", vs_cnt, 32);
        check("frame_cnt_after_1", a_fc, 1);
        check("b_frame_cnt_after_1", b_fc, 1);
        check_state(0, 0);

        // ce pattern 1,0,0,1
        ce = 1'b1; tick();
        check("ce1_hcount", a_h, 1);
        check("ce1_line_start", a_ls, 0);
        ce = 1'b0; tick();
        check("ce0a_hcount", a_h, 1);
        check("ce0a_vis", a_vis, 1);
        check("ce0a_line_start", a_ls, 0);
        ce = 1'b0; tick();
        check("ce0b_hcount", a_h, 1);
        check("ce0b_frame_start", a_fs, 0);
        check("ce0b_b_hsync_n", b_hs, 1);
        ce = 1'b1; tick();
        check("ce1b_hcount", a_h, 2);

        // Frame period counted in ce-high cycles under random enable
        measure_period(n, ok);
        check("period_rest_done", ok, 1);
        check("period_rest_len", n, 126);
        check("frame_cnt_after_2", a_fc, 2);
        measure_period(n, ok);
        check("period_full_done", ok, 1);
        check("period_full_len", n, 128);
        check("frame_cnt_after_3", a_fc, 3);
        check("b_frame_cnt_after_3", b_fc, 3);

        // Frame counter wrap on the 2-bit instance
        ce = 1'b1;
        for (int i = 0; i < 128; i++) tick();
        check("frame_cnt_after_4", a_fc, 4);
        check("b_frame_cnt_wrap", b_fc, 0);
        check_state(0, 0);

        // Mid-frame reset at (13,6) with ce low
        for (int i = 0; i < 109; i++) tick();
        check("pre_rst_hcount", a_h, 13);
        check("pre_rst_vcount", a_v, 6);
        check("pre_rst_vsync", a_vs, 1);
        ce = 1'b0; rst = 1'b1;
        tick();
        check("mid_rst_hcount", a_h, 0);
        check("mid_rst_vcount", a_v, 0);
        check("mid_rst_frame_cnt", a_fc, 0);
        check("mid_rst_b_frame_cnt", b_fc, 0);
        check("mid_rst_vsync", a_vs, 0);
        check("mid_rst_frame_start", a_fs, 1);
        check("mid_rst_b_hsync_n", b_hs, 1);
        ce = 1'b1;
        tick();
        check("rst_over_ce_hcount", a_h, 0);
        rst = 1'b0;
        tick();
        check("first_ce_hcount", a_h, 1);
        check("first_ce_vcount", a_v, 0);
        check("first_ce_frame_start", a_fs, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
